reg_file_rd_rsp: RTL and testbench

REG_FILE_RD_RSP -- requirements
Module: reg_file_rd_rsp

---
 rtl/reg_file_rd_rsp_if.sv | 46 ++++
 rtl/reg_file_rd_rsp.sv | 79 +++++++
 tb/tb_reg_file_rd_rsp.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_rd_rsp_if.sv
// rtl/reg_file_rd_rsp_if.sv - read-request / write / read-response bundle for reg_file_rd_rsp
//
// Purpose: groups the per-port read request and response handshakes and the
// single write port of the register file.
// Ports (signals):
//   reg_file_rd_req_vld/pkt/rdy  per-port read request (pkt.addr)
//   reg_file_wr_vld/addr/data    write port, never back-pressured
//   reg_file_rd_rsp_vld/pkt/rdy  per-port read response (pkt.data)
// Modports: master = requester/consumer side, slave = register file side.
interface reg_file_rd_rsp_if #(
  parameter int NUM_RD_PORTS = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
  } reg_file_rd_req_pkt_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } reg_file_rd_rsp_pkt_t;

  logic                 [NUM_RD_PORTS-1:0] reg_file_rd_req_vld;
  reg_file_rd_req_pkt_t [NUM_RD_PORTS-1:0] reg_file_rd_req_pkt;
  logic                 [NUM_RD_PORTS-1:0] reg_file_rd_req_rdy;
  logic                                    reg_file_wr_vld;
  logic                 [ADDR_W-1:0]       reg_file_wr_addr;
  logic                 [DATA_W-1:0]       reg_file_wr_data;
  logic                 [NUM_RD_PORTS-1:0] reg_file_rd_rsp_vld;
  reg_file_rd_rsp_pkt_t [NUM_RD_PORTS-1:0] reg_file_rd_rsp_pkt;
  logic                 [NUM_RD_PORTS-1:0] reg_file_rd_rsp_rdy;

  modport master (
    output reg_file_rd_req_vld, reg_file_rd_req_pkt,
    output reg_file_wr_vld, reg_file_wr_addr, reg_file_wr_data,
    output reg_file_rd_rsp_rdy,
    input  reg_file_rd_req_rdy, reg_file_rd_rsp_vld, reg_file_rd_rsp_pkt
  );

  modport slave (
    input  reg_file_rd_req_vld, reg_file_rd_req_pkt,
    input  reg_file_wr_vld, reg_file_wr_addr, reg_file_wr_data,
    input  reg_file_rd_rsp_rdy,
    output reg_file_rd_req_rdy, reg_file_rd_rsp_vld, reg_file_rd_rsp_pkt
  );
endinterface

// File: rtl/reg_file_rd_rsp.sv
// rtl/reg_file_rd_rsp.sv - multi-port register file with 1-cycle buffered read responses
//
// Purpose: 2^ADDR_W x DATA_W register file (r0 hard-wired to zero) with
// NUM_RD_PORTS independent read ports. Each port owns a one-entry response
// buffer; a read is accepted when that buffer is empty or draining this cycle,
// and its data is snapshotted at the accept edge (same-cycle write bypassed).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears registers and response buffers
//   bus    reg_file_rd_rsp_if.slave (read requests, write port, read responses)
module reg_file_rd_rsp #(
  parameter int NUM_RD_PORTS = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_file_rd_rsp_if.slave      bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]       regs [NUM_REGS];
  logic [NUM_RD_PORTS-1:0] rsp_vld_q;
  logic [DATA_W-1:0]       rsp_data_q [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] req_rdy;
  logic [NUM_RD_PORTS-1:0] accept;
  logic [DATA_W-1:0]       rd_data [NUM_RD_PORTS];

  // Buffer can take a new request when empty or when its current entry leaves now.
  assign req_rdy = ~rsp_vld_q | bus.reg_file_rd_rsp_rdy;
  assign accept  = bus.reg_file_rd_req_vld & req_rdy;

  assign bus.reg_file_rd_req_rdy = req_rdy;
  assign bus.reg_file_rd_rsp_vld = rsp_vld_q;

  for (genvar gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_rsp_pkt
    assign bus.reg_file_rd_rsp_pkt[gp] = rsp_data_q[gp];
  end

  // Read value seen at the accept edge: r0 is zero, a write to the same
  // register in the same cycle is forwarded so the response is never stale.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_data[p] = regs[bus.reg_file_rd_req_pkt[p].addr];
      if (bus.reg_file_rd_req_pkt[p].addr == '0) begin
        rd_data[p] = '0;
      end else if (bus.reg_file_wr_vld &&
                   (bus.reg_file_wr_addr == bus.reg_file_rd_req_pkt[p].addr)) begin
        rd_data[p] = bus.reg_file_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.reg_file_wr_vld && (bus.reg_file_wr_addr != '0)) begin
      regs[bus.reg_file_wr_addr] <= bus.reg_file_wr_data;
    end
  end

  // Response buffer: load on accept, otherwise drain on handshake; while
  // stalled the snapshot is held regardless of later register writes.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (reset) begin
        rsp_vld_q[p]  <= 1'b0;
        rsp_data_q[p] <= '0;
      end else if (accept[p]) begin
        rsp_vld_q[p]  <= 1'b1;
        rsp_data_q[p] <= rd_data[p];
      end else if (bus.reg_file_rd_rsp_rdy[p]) begin
        rsp_vld_q[p]  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_rd_rsp.sv
// tb/tb_reg_file_rd_rsp.sv - self-checking bench for reg_file_rd_rsp
module tb_reg_file_rd_rsp;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_rd_rsp_if #(.NUM_RD_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_file_rd_rsp #(.NUM_RD_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: architectural register contents plus, per port, the queue of
  // responses owed to the consumer (oldest at the front).
  logic [DW-1:0] m_regs [2**AW];
  logic [DW-1:0] exp_q  [NP][$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (bus.reg_file_wr_vld && bus.reg_file_wr_addr == a) return bus.reg_file_wr_data;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) m_regs[i] = '0;
      for (int p = 0; p < NP; p++) exp_q[p].delete();
    end else begin
      for (int p = 0; p < NP; p++) begin
        bit room;
        room = (exp_q[p].size() == 0) || bus.reg_file_rd_rsp_rdy[p];
        if (exp_q[p].size() != 0 && bus.reg_file_rd_rsp_rdy[p]) void'(exp_q[p].pop_front());
        if (bus.reg_file_rd_req_vld[p] && room)
          exp_q[p].push_back(model_read(bus.reg_file_rd_req_pkt[p].addr));
      end
      if (bus.reg_file_wr_vld && bus.reg_file_wr_addr != 0)
        m_regs[bus.reg_file_wr_addr] = bus.reg_file_wr_data;
    end
  end

  // Compare process: every non-reset cycle, on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rsp_vld[%0d]", p), 64'(bus.reg_file_rd_rsp_vld[p]),
            64'(exp_q[p].size() != 0));
        chk($sformatf("req_rdy[%0d]", p), 64'(bus.reg_file_rd_req_rdy[p]),
            64'((exp_q[p].size() == 0) || bus.reg_file_rd_rsp_rdy[p]));
        if (exp_q[p].size() != 0 && bus.reg_file_rd_rsp_vld[p])
          chk($sformatf("rsp_data[%0d]", p), 64'(bus.reg_file_rd_rsp_pkt[p].data),
              64'(exp_q[p][0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.reg_file_rd_req_vld = '0;
    bus.reg_file_rd_req_pkt = '0;
  endtask

  task automatic clear_wr();
    bus.reg_file_wr_vld  = 1'b0;
    bus.reg_file_wr_addr = '0;
    bus.reg_file_wr_data = '0;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.reg_file_wr_vld  = 1'b1;
    bus.reg_file_wr_addr = a;
    bus.reg_file_wr_data = d;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a);
    bus.reg_file_rd_req_vld[p]      = 1'b1;
    bus.reg_file_rd_req_pkt[p].addr = a;
  endtask

  initial begin
    reset = 1'b1;
    clear_req();
    clear_wr();
    bus.reg_file_rd_rsp_rdy = '1;
    // Request and write presented during reset must be dropped.
    set_req(0, 5'd4);
    set_wr(5'd4, 32'hCAFE0001);
    tick();
    tick();
    reset = 1'b0;
    clear_req();
    clear_wr();
    bus.reg_file_rd_rsp_rdy = '0;
    #1;
    chk("reset rsp_vld", 64'(bus.reg_file_rd_rsp_vld), 64'd0);
    chk("reset req_rdy", 64'(bus.reg_file_rd_req_rdy), 64'h3);
    bus.reg_file_rd_rsp_rdy = '1;
    set_req(0, 5'd4);
    tick();
    clear_req();
    chk("write during reset dropped", 64'(bus.reg_file_rd_rsp_pkt[0].data), 64'd0);

    // Basic write then read.
    set_wr(5'd5, 32'hDEADBEEF);
    tick();
    clear_wr();
    set_req(0, 5'd5);
    tick();
    clear_req();
    chk("basic vld", 64'(bus.reg_file_rd_rsp_vld[0]), 64'd1);
    chk("basic data", 64'(bus.reg_file_rd_rsp_pkt[0].data), 64'hDEADBEEF);
    tick();

    // Bypass, and r0 ignores writes (including a same-cycle write).
    set_wr(5'd7, 32'h12345678);
    set_req(1, 5'd7);
    tick();
    clear_wr();
    clear_req();
    chk("bypass data", 64'(bus.reg_file_rd_rsp_pkt[1].data), 64'h12345678);
    set_wr(5'd0, 32'hFFFFFFFF);
    set_req(1, 5'd0);
    tick();
    clear_wr();
    clear_req();
    chk("r0 same-cycle", 64'(bus.reg_file_rd_rsp_pkt[1].data), 64'd0);
    set_req(0, 5'd0);
    tick();
    clear_req();
    chk("r0 read", 64'(bus.reg_file_rd_rsp_pkt[0].data), 64'd0);

    // Backpressure with snapshot stability.
    set_wr(5'd3, 32'hA);
    tick();
    clear_wr();
    bus.reg_file_rd_rsp_rdy[0] = 1'b0;
    set_req(0, 5'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_wr(5'd3, 32'hB);
      tick();
      chk("stall vld", 64'(bus.reg_file_rd_rsp_vld[0]), 64'd1);
      chk("stall data", 64'(bus.reg_file_rd_rsp_pkt[0].data), 64'hA);
      chk("stall rdy", 64'(bus.reg_file_rd_req_rdy[0]), 64'd0);
    end
    clear_wr();
    clear_req();
    bus.reg_file_rd_rsp_rdy[0] = 1'b1;
    tick();
    chk("drain vld", 64'(bus.reg_file_rd_rsp_vld[0]), 64'd0);
    set_req(0, 5'd3);
    tick();
    clear_req();
    chk("post-stall data", 64'(bus.reg_file_rd_rsp_pkt[0].data), 64'hB);

    // Throughput: 8 back-to-back reads on both ports.
    for (int i = 1; i <= 8; i++) begin
      set_wr(5'(i), 32'h100 + 32'(i));
      tick();
    end
    clear_wr();
    for (int i = 1; i <= 8; i++) begin
      set_req(0, 5'(i));
      set_req(1, 5'(i));
      tick();
      chk("b2b vld", 64'(bus.reg_file_rd_rsp_vld), 64'h3);
      chk("b2b data0", 64'(bus.reg_file_rd_rsp_pkt[0].data), 64'h100 + 64'(i));
      chk("b2b data1", 64'(bus.reg_file_rd_rsp_pkt[1].data), 64'h100 + 64'(i));
    end
    clear_req();
    tick();

    // Reset while a response is stalled.
    set_wr(5'd9, 32'h55);
    tick();
    clear_wr();
    bus.reg_file_rd_rsp_rdy = '0;
    set_req(0, 5'd9);
    tick();
    clear_req();
    chk("pre-reset data", 64'(bus.reg_file_rd_rsp_pkt[0].data), 64'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset discards vld", 64'(bus.reg_file_rd_rsp_vld), 64'd0);
    tick();
    chk("no late rsp", 64'(bus.reg_file_rd_rsp_vld), 64'd0);
    bus.reg_file_rd_rsp_rdy = '1;
    set_req(0, 5'd9);
    tick();
    clear_req();
    chk("r9 after reset", 64'(bus.reg_file_rd_rsp_pkt[0].data), 64'd0);

    // Constrained random: small address window to force collisions and bypass.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.reg_file_wr_vld  = ($urandom_range(0, 1) == 1);
      bus.reg_file_wr_addr = 5'($urandom_range(0, 7));
      bus.reg_file_wr_data = $urandom;
      for (int p = 0; p < NP; p++) begin
        bus.reg_file_rd_req_vld[p]      = ($urandom_range(0, 3) != 0);
        bus.reg_file_rd_req_pkt[p].addr = 5'($urandom_range(0, 7));
        bus.reg_file_rd_rsp_rdy[p]      = ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    reset = 1'b0;
    clear_req();
    clear_wr();
    bus.reg_file_rd_rsp_rdy = '1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
